// File: rtl/bitsplit_sequencer_pkg.sv
// Shared BitBlade definitions: precision codes, FSM states, slice-count map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitsplit_sequencer_pkg;

    localparam logic [1:0] P2 = 2'b00;
    localparam logic [1:0] P4 = 2'b01;
    localparam logic [1:0] P8 = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Code 11 falls into the 8b bucket.
    function automatic logic [2:0] slice_count(input logic [1:0] prec);
        case (prec)
            P2:      return 3'd1;
            P4:      return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bitsplit_sequencer_if.sv
// Operand-in / slice-out handshake bundle for the bit-split sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, slice_valid/slice_ready downstream.
interface bitsplit_sequencer_if #(
    parameter int SLICE_W = 2,
    parameter int OP_W    = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    act;
    logic [OP_W-1:0]    wgt;
    logic [1:0]         act_prec;
    logic [1:0]         wgt_prec;
    logic               slice_valid;
    logic               slice_ready;
    logic [SLICE_W:0]   act_slice;
    logic [SLICE_W:0]   wgt_slice;
    logic [3:0]         shift;
    logic               last;

    modport slave (
        input  in_valid, act, wgt, act_prec, wgt_prec, slice_ready,
        output in_ready, slice_valid, act_slice, wgt_slice, shift, last
    );

    modport master (
        output in_valid, act, wgt, act_prec, wgt_prec, slice_ready,
        input  in_ready, slice_valid, act_slice, wgt_slice, shift, last
    );
endinterface

// File: rtl/bitsplit_slice_sel.sv
// Picks slice idx of an operand; sign-extends the top slice, zero-extends others.
// Latency: combinational.
// Backpressure: none.
module bitsplit_slice_sel #(
    parameter int SLICE_W = 2,
    parameter int OP_W    = 8
) (
    input  logic [OP_W-1:0]  operand_i,
    input  logic [1:0]       idx_i,
    input  logic [2:0]       n_i,
    output logic [SLICE_W:0] slice_o
);
    logic [OP_W-1:0]    shifted;
    logic [SLICE_W-1:0] raw;
    logic               top;

    always_comb begin
        shifted = operand_i >> (int'(idx_i) * SLICE_W);
        raw     = shifted[SLICE_W-1:0];
        top     = ({1'b0, idx_i} == (n_i - 3'd1));
        slice_o = {top & raw[SLICE_W-1], raw};
    end
endmodule

// File: rtl/bitsplit_sequencer.sv
// Splits an act/wgt pair into slice pairs (act inner, wgt outer) with shift amounts.
// Latency: first pair one cycle after accept; back-to-back ops without a bubble.
// Backpressure: slice_ready low freezes all registered outputs; in_ready only on idle or last fire.
module bitsplit_sequencer #(
    parameter int SLICE_W = 2,
    parameter int OP_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bitsplit_sequencer_if.slave   bus
);
    import bitsplit_sequencer_pkg::*;

    state_t            state_q, state_d;
    logic [1:0]        i_q, i_d, j_q, j_d;
    logic [2:0]        na_q, na_d, nw_q, nw_d;
    logic [OP_W-1:0]   act_q, act_d, wgt_q, wgt_d;
    logic              slice_valid_q, slice_valid_d;
    logic              last_q, last_d;
    logic [SLICE_W:0]  act_slice_q, act_slice_d, wgt_slice_q, wgt_slice_d;
    logic [3:0]        shift_q, shift_d;
    logic [SLICE_W:0]  act_sel, wgt_sel;
    logic              fire, accept, in_ready;

    assign fire     = slice_valid_q & bus.slice_ready;
    assign in_ready = (state_q == IDLE) | (last_q & bus.slice_ready);
    assign accept   = bus.in_valid & in_ready;

    // Selectors look at the next-state indices so the output registers load the upcoming pair.
    bitsplit_slice_sel #(.SLICE_W(SLICE_W), .OP_W(OP_W)) u_act_sel (
        .operand_i (act_d),
        .idx_i     (i_d),
        .n_i       (na_d),
        .slice_o   (act_sel)
    );

    bitsplit_slice_sel #(.SLICE_W(SLICE_W), .OP_W(OP_W)) u_wgt_sel (
        .operand_i (wgt_d),
        .idx_i     (j_d),
        .n_i       (nw_d),
        .slice_o   (wgt_sel)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        na_d    = na_q;
        nw_d    = nw_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        if (accept) begin
            state_d = ISSUE;
            i_d     = 2'd0;
            j_d     = 2'd0;
            na_d    = slice_count(bus.act_prec);
            nw_d    = slice_count(bus.wgt_prec);
            act_d   = bus.act;
            wgt_d   = bus.wgt;
        end else if (fire) begin
            if (last_q) begin
                state_d = IDLE;
                i_d     = 2'd0;
                j_d     = 2'd0;
            end else if ({1'b0, i_q} == (na_q - 3'd1)) begin
                i_d = 2'd0;
                j_d = j_q + 2'd1;
            end else begin
                i_d = i_q + 2'd1;
            end
        end

        slice_valid_d = (state_d == ISSUE);
        act_slice_d   = slice_valid_d ? act_sel : '0;
        wgt_slice_d   = slice_valid_d ? wgt_sel : '0;
        shift_d       = slice_valid_d ? 4'(({1'b0, i_d} + {1'b0, j_d}) * SLICE_W) : 4'd0;
        last_d        = slice_valid_d && ({1'b0, i_d} == (na_d - 3'd1))
                                      && ({1'b0, j_d} == (nw_d - 3'd1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            na_q          <= '0;
            nw_q          <= '0;
            act_q         <= '0;
            wgt_q         <= '0;
            slice_valid_q <= 1'b0;
            last_q        <= 1'b0;
            act_slice_q   <= '0;
            wgt_slice_q   <= '0;
            shift_q       <= '0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            na_q          <= na_d;
            nw_q          <= nw_d;
            act_q         <= act_d;
            wgt_q         <= wgt_d;
            slice_valid_q <= slice_valid_d;
            last_q        <= last_d;
            act_slice_q   <= act_slice_d;
            wgt_slice_q   <= wgt_slice_d;
            shift_q       <= shift_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.slice_valid = slice_valid_q;
    assign bus.act_slice   = act_slice_q;
    assign bus.wgt_slice   = wgt_slice_q;
    assign bus.shift       = shift_q;
    assign bus.last        = last_q;
endmodule

// File: tb/tb_bitsplit_sequencer.sv
// Scoreboarded directed bench for bitsplit_sequencer: hand-computed slice tables feed a queue, a monitor pops on every fire.
module tb_bitsplit_sequencer;
    import bitsplit_sequencer_pkg::*;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] w;
        logic [3:0] sh;
        logic       last;
    } pair_t;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fires = 0;
    pair_t sb[$];

    bitsplit_sequencer_if #(.SLICE_W(2), .OP_W(8)) bus ();

    bitsplit_sequencer #(.SLICE_W(2), .OP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Slice tables are indexed by slice number k (entry [k]).
    task automatic push_tab(input int na, input int nw,
                            input logic [3:0][2:0] at, input logic [3:0][2:0] wt);
        pair_t p;
        for (int j = 0; j < nw; j++) begin
            for (int i = 0; i < na; i++) begin
                p.a    = at[i];
                p.w    = wt[j];
                p.sh   = 4'(2 * (i + j));
                p.last = (i == na - 1) && (j == nw - 1);
                sb.push_back(p);
            end
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] w,
                        input logic [1:0] ap, input logic [1:0] wp);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.act      = a;
        bus.wgt      = w;
        bus.act_prec = ap;
        bus.wgt_prec = wp;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.act      = 8'($urandom);
        bus.wgt      = 8'($urandom);
        bus.act_prec = 2'($urandom);
        bus.wgt_prec = 2'($urandom);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !bus.slice_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_fires(input int target);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (fires == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("fire_timeout", 0, 1);
        #1;
    endtask

    // Monitor: pops on every fire and checks outputs stay frozen across stalls.
    pair_t cur, held, exp_p;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (!reset && bus.slice_valid) begin
            cur = '{a: bus.act_slice, w: bus.wgt_slice, sh: bus.shift, last: bus.last};
            if (stalled) chk("stall_hold", 32'(cur), 32'(held));
            if (bus.slice_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pair", 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    exp_p = sb.pop_front();
                    chk("pair", 32'(cur), 32'(exp_p));
                end
                fires++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = cur;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int base;
    bit ok_b2b;
    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.act         = '0;
        bus.wgt         = '0;
        bus.act_prec    = '0;
        bus.wgt_prec    = '0;
        bus.slice_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_slice_valid", {31'd0, bus.slice_valid}, 0);
        chk("rst_in_ready",    {31'd0, bus.in_ready},    1);
        chk("rst_outputs",     {21'd0, bus.act_slice, bus.wgt_slice, bus.shift, bus.last}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 2b x 2b: 03 -> top slice 11 = 111, 01 -> 001.
        push_tab(1, 1, {3'b000, 3'b000, 3'b000, 3'b111}, {3'b000, 3'b000, 3'b000, 3'b001});
        send(8'h03, 8'h01, P2, P2);
        drain("t1_drain");
        chk("t1_in_ready", {31'd0, bus.in_ready}, 1);

        // 8b x 8b: B4 slices 00,01,11,10 ; 7F slices 11,11,11,01.
        push_tab(4, 4, {3'b110, 3'b011, 3'b001, 3'b000}, {3'b001, 3'b011, 3'b011, 3'b011});
        send(8'hB4, 8'h7F, P8, P8);
        drain("t2_drain");

        // 4b x 8b with a 3-cycle stall on pair 5: 09 -> 001,110 ; 80 -> 000,000,000,110.
        push_tab(2, 4, {3'b000, 3'b000, 3'b110, 3'b001}, {3'b110, 3'b000, 3'b000, 3'b000});
        base = fires;
        send(8'h09, 8'h80, P4, P8);
        wait_fires(base + 5);
        bus.slice_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.slice_ready = 1'b1;
        drain("t3_drain");
        chk("t3_fire_count", 32'(fires - base), 8);

        // Back-to-back: 2b x 4b (02 ; 0D) then 4b x 2b (07 ; 02) held on in_valid.
        push_tab(1, 2, {3'b000, 3'b000, 3'b000, 3'b110}, {3'b000, 3'b000, 3'b111, 3'b001});
        push_tab(2, 1, {3'b000, 3'b000, 3'b001, 3'b011}, {3'b000, 3'b000, 3'b000, 3'b110});
        base = fires;
        send(8'h02, 8'h0D, P2, P4);
        bus.in_valid = 1'b1;
        bus.act      = 8'h07;
        bus.wgt      = 8'h02;
        bus.act_prec = P4;
        bus.wgt_prec = P2;
        ok_b2b = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("b2b_valid_held", {31'd0, bus.slice_valid}, 1);
            if (bus.in_ready) begin
                ok_b2b = 1'b1;
                break;
            end
        end
        chk("b2b_accept", {31'd0, ok_b2b}, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_next_valid", {31'd0, bus.slice_valid}, 1);
        chk("b2b_next_shift", {28'd0, bus.shift}, 0);
        drain("t4_drain");
        chk("t4_fire_count", 32'(fires - base), 4);

        // Reset after 5 fires of 8x8 (wgt_prec 11 = 8b): 5A -> 010,010,001,001 ; C3 -> 011,000,000,111.
        push_tab(4, 4, {3'b001, 3'b001, 3'b010, 3'b010}, {3'b111, 3'b000, 3'b000, 3'b011});
        base = fires;
        send(8'h5A, 8'hC3, P8, 2'b11);
        wait_fires(base + 5);
        reset = 1'b1;
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_slice_valid", {31'd0, bus.slice_valid}, 0);
            chk("mid_rst_in_ready",    {31'd0, bus.in_ready},    1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {31'd0, bus.slice_valid}, 0);
        push_tab(1, 1, {3'b000, 3'b000, 3'b000, 3'b110}, {3'b000, 3'b000, 3'b000, 3'b111});
        base = fires;
        send(8'h02, 8'h03, P2, P2);
        drain("t5_drain");
        chk("t5_fire_count", 32'(fires - base), 1);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bitsplit_sequencer.md
BITSPLIT_SEQUENCER -- requirements
Module: bitsplit_sequencer

Interface
REQ-001 SHALL have parameter SLICE_W, default 2, giving the width in bits of one operand slice.
REQ-002 SHALL have parameter OP_W, default 8, giving the maximum operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 SHALL have port act, input, 8 bits: activation, two's complement, right-aligned to its precision.
REQ-008 SHALL have port wgt, input, 8 bits: weight, two's complement, right-aligned to its precision.
REQ-009 SHALL have port act_prec, input, 2 bits: activation precision; 00 = 2b, 01 = 4b, 10 = 8b, 11 = treated as 8b.
REQ-010 SHALL have port wgt_prec, input, 2 bits: weight precision, same encoding as act_prec.
REQ-011 SHALL have port slice_valid, output, 1 bit: a slice pair is presented.
REQ-012 SHALL have port slice_ready, input, 1 bit: the downstream PE consumes the pair.
REQ-013 SHALL have port act_slice, output, 3 bits: activation slice, extended to 3 bits.
REQ-014 SHALL have port wgt_slice, output, 3 bits: weight slice, extended to 3 bits.
REQ-015 SHALL have port shift, output, 4 bits: left-shift amount for the pair's partial product.
REQ-016 SHALL have port last, output, 1 bit: the presented pair is the final pair of its operation.

Function
REQ-017 SHALL compute the slice count as Na = 1, 2 or 4 from act_prec and Nw = 1, 2 or 4 from wgt_prec, latched on accept.
REQ-018 SHALL define slice k of an operand as bits [2k+1:2k].
REQ-019 SHALL sign-extend the top slice (k = N-1) to 3 bits and zero-extend every other slice (giving 000..011 for non-top slices and 110..001 for the top slice).
REQ-020 SHALL implement FSM states IDLE and ISSUE.
REQ-021 IDLE: in_ready = 1 and slice_valid = 0; in_valid high moves the FSM to ISSUE with i = 0, j = 0.
REQ-022 ISSUE: slice_valid = 1 and the pair (i, j) is presented, where i indexes the activation slice and j the weight slice.
REQ-023 SHALL set shift = 2*(i+j); the maximum is 12.
REQ-024 SHALL iterate with i as the inner loop and j as the outer loop, advancing only on fire (slice_valid & slice_ready).
REQ-025 SHALL, at i = Na-1 on fire, set i to 0 and increment j.
REQ-026 SHALL assert last = 1 exactly when i = Na-1 and j = Nw-1.
REQ-027 SHALL make a fire with last = 1 return the FSM to IDLE, unless a new operand is accepted in the same cycle.
REQ-028 SHALL drive in_ready = IDLE | (last & slice_ready), allowing back-to-back operations with no bubble; an accept on the last fire loads the new operands, resets i and j to 0 and keeps the FSM in ISSUE.
REQ-029 SHALL, while slice_valid = 1 and slice_ready = 0, hold all outputs stable.
REQ-030 SHALL register all outputs except in_ready.
REQ-031 SHALL place the first pair on the outputs in the cycle after accept (latency 1).
REQ-032 SHALL ignore act, wgt and the precision inputs when no accept occurs.

Reset
REQ-033 SHALL, on reset assertion, immediately drive state = IDLE, i = j = 0, all latched operands = 0, slice_valid = 0, last = 0, act_slice = wgt_slice = 000 and shift = 0, so in_ready = 1.
REQ-034 SHALL abandon an in-progress operation on reset with no further pairs issued; the first accept after reset starts at pair (0,0).

Structure
REQ-035 SHALL place the precision encodings (P2 = 00, P4 = 01, P8 = 10), the FSM state codes and the slice-count mapping in the shared BitBlade package/include.
REQ-036 SHALL instantiate one sub-module bitsplit_slice_sel per operand: a combinational block that takes the operand, slice index and N and returns the 3-bit extended slice.

Verification
REQ-037 SHALL cover 2b x 2b: act = 8'h03, wgt = 8'h01 -> one pair: act_slice = 111, wgt_slice = 001, shift = 0, last = 1; in_ready high the next cycle.
REQ-038 SHALL cover 8b x 8b: act = 8'hB4, wgt = 8'h7F -> 16 pairs; first pair 000/011 with shift = 0; fourth pair (i = 3) 110/011 with shift = 6; final pair 110/001 with shift = 12 and last = 1.
REQ-039 SHALL cover 4b x 8b: act = 8'h09, wgt = 8'h80 -> 8 pairs with shifts 0, 2, 2, 4, 4, 6, 6, 8.
REQ-040 SHALL cover backpressure: slice_ready low for 3 cycles at pair 5 -> outputs identical across those cycles and no pair skipped or duplicated.
REQ-041 SHALL cover back-to-back: in_valid held high through the last fire -> next cycle shows pair (0,0) of the new operation with slice_valid never dropping.
REQ-042 SHALL cover reset mid-operation: reset pulsed after 5 fires of 8x8 -> slice_valid = 0 and in_ready = 1 during reset; the next operation starts at shift = 0.
